axi_ar_xbar: RTL

//  Parametrised AXI read-address (AR) crossbar. Connects NM masters to NS slaves.
//  - Round-robin arbitration with a registered grant.
//  - Address decode from a base/mask table.
//  - Per-slave outstanding-read limiting.
//  - ARID extended with the master index.

---
 rtl/axi_xbar_pkg.sv | 38 +++
 rtl/axi_rr_arbiter.sv | 24 ++
 rtl/axi_ar_xbar.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/axi_xbar_pkg.sv
// rtl/axi_xbar_pkg.sv - shared AXI crossbar types, AR decode tables and default AXI field widths
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

package axi_xbar_pkg;

    // One entry per decoded slave; the last slave (default) has no entry.
    localparam int AR_TABLE_N = 5;

    localparam logic [AR_TABLE_N-1:0][31:0] AR_BASE = {
        32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };

    localparam logic [AR_TABLE_N-1:0][31:0] AR_MASK = {
        32'hC000_0000, 32'hFF00_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000
    };

    typedef struct packed {
        logic [`AXI_ID_BITS-1:0]   id;
        logic [31:0]               addr;
        logic [`AXI_LEN_BITS-1:0]  len;
        logic [`AXI_SIZE_BITS-1:0] size;
        logic [1:0]                burst;
    } ar_req_t;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

endpackage

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - combinational round-robin arbiter: first requester at or after ptr, wrapping
module axi_rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx
);

    // Scan from the farthest position back to ptr so the nearest requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt = '0;
                gnt[(int'(ptr) + k) % N] = 1'b1;
                idx = ($clog2(N))'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/axi_ar_xbar.sv
// rtl/axi_ar_xbar.sv - AXI AR crossbar: round-robin grant, base/mask decode, per-slave outstanding limit
// Option macro AXI_AR_OUTREG_EN: slave-side payload driven from an output register.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif

module axi_ar_xbar
    import axi_xbar_pkg::*;
#(
    parameter int NM        = 2,
    parameter int NS        = 6,
    parameter int ID_W      = `AXI_ID_BITS,
    parameter int MAX_OUTST = 4,
    parameter logic [NS-2:0][31:0] BASE = AR_BASE,
    parameter logic [NS-2:0][31:0] MASK = AR_MASK
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NM-1:0][ID_W-1:0]                ARID_M,
    input  logic [NM-1:0][31:0]                    ARADDR_M,
    input  logic [NM-1:0][`AXI_LEN_BITS-1:0]       ARLEN_M,
    input  logic [NM-1:0][`AXI_SIZE_BITS-1:0]      ARSIZE_M,
    input  logic [NM-1:0][1:0]                     ARBURST_M,
    input  logic [NM-1:0]                          ARVALID_M,
    output logic [NM-1:0]                          ARREADY_M,
    output logic [ID_W+$clog2(NM)-1:0]             ARID_S,
    output logic [31:0]                            ARADDR_S,
    output logic [`AXI_LEN_BITS-1:0]               ARLEN_S,
    output logic [`AXI_SIZE_BITS-1:0]              ARSIZE_S,
    output logic [1:0]                             ARBURST_S,
    output logic [NS-1:0]                          ARVALID_S,
    input  logic [NS-1:0]                          ARREADY_S,
    input  logic [NS-1:0]                          RDONE_S,
    output logic [NS-1:0]                          outst_full
);

    localparam int MW = $clog2(NM);
    localparam int SW = $clog2(NS);
    localparam int CW = $clog2(MAX_OUTST + 1);

    state_t                 state;
    logic [MW-1:0]          grant;
    logic [MW-1:0]          rr_ptr;
    logic [MW-1:0]          arb_idx;
    logic [SW-1:0]          target;
    logic [NM-1:0]          elig;
    logic [NM-1:0]          arb_gnt;
    logic [NM-1:0][SW-1:0]  tgt_m;
    logic [NS-1:0][CW-1:0]  cnt;
    logic [NS-1:0]          slv_hs;
    ar_req_t                sel_req;

    // Lowest matching entry wins; anything unmatched goes to the default slave.
    function automatic logic [SW-1:0] decode(input logic [31:0] a);
        decode = SW'(NS - 1);
        for (int i = NS - 2; i >= 0; i--) begin
            if ((a & MASK[i]) == BASE[i]) decode = SW'(i);
        end
    endfunction

    always_comb begin
        for (int m = 0; m < NM; m++) begin
            tgt_m[m] = decode(ARADDR_M[m]);
            elig[m]  = ARVALID_M[m] && !outst_full[tgt_m[m]];
        end
    end

    axi_rr_arbiter #(.N(NM)) u_arb (
        .req (elig),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            grant  <= '0;
            target <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: if (|arb_gnt) begin
                    grant  <= arb_idx;
                    target <= tgt_m[arb_idx];
                    state  <= GRANT;
                end
                GRANT: if (ARREADY_S[target]) begin
                    state  <= IDLE;
                    rr_ptr <= (grant == MW'(NM - 1)) ? '0 : grant + MW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef AXI_AR_OUTREG_EN
    ar_req_t out_req;

    always_comb begin
        sel_req = '{id: ARID_M[arb_idx], addr: ARADDR_M[arb_idx], len: ARLEN_M[arb_idx],
                    size: ARSIZE_M[arb_idx], burst: ARBURST_M[arb_idx]};
    end

    // Master is released at grant time; the register carries the request to the slave.
    always_ff @(posedge clk) begin
        if (rst) out_req <= '0;
        else if (state == IDLE && |arb_gnt) out_req <= sel_req;
    end

    always_comb begin
        ARREADY_M = (state == IDLE) ? arb_gnt : '0;
        ARVALID_S = '0;
        if (state == GRANT) ARVALID_S[target] = 1'b1;
        ARID_S    = {grant, out_req.id};
        ARADDR_S  = out_req.addr;
        ARLEN_S   = out_req.len;
        ARSIZE_S  = out_req.size;
        ARBURST_S = out_req.burst;
    end
`else
    always_comb begin
        sel_req = '{id: ARID_M[grant], addr: ARADDR_M[grant], len: ARLEN_M[grant],
                    size: ARSIZE_M[grant], burst: ARBURST_M[grant]};
        ARREADY_M = '0;
        ARVALID_S = '0;
        ARID_S    = '0;
        ARADDR_S  = '0;
        ARLEN_S   = '0;
        ARSIZE_S  = '0;
        ARBURST_S = '0;
        if (state == GRANT) begin
            ARREADY_M[grant]  = ARREADY_S[target];
            ARVALID_S[target] = 1'b1;
            ARID_S    = {grant, sel_req.id};
            ARADDR_S  = sel_req.addr;
            ARLEN_S   = sel_req.len;
            ARSIZE_S  = sel_req.size;
            ARBURST_S = sel_req.burst;
        end
    end
`endif

    assign slv_hs = ARVALID_S & ARREADY_S;

    // A completion arriving with the counter already at zero is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                case ({slv_hs[s], RDONE_S[s] && (cnt[s] != '0)})
                    2'b10:   cnt[s] <= cnt[s] + CW'(1);
                    2'b01:   cnt[s] <= cnt[s] - CW'(1);
                    default: cnt[s] <= cnt[s];
                endcase
            end
        end
    end

    always_comb begin
        for (int s = 0; s < NS; s++) outst_full[s] = (cnt[s] == CW'(MAX_OUTST));
    end

endmodule
